// File: rtl/merge_stage.sv
// merge_stage: 2-to-1 fan-in for the data-driven pipeline.
// Two four-phase Send/Ack input channels share one packet buffer; a round-robin
// pointer breaks ties so that neither channel is granted twice in a row while
// the other is waiting. The buffered packet leaves on a four-phase output channel.
module merge_stage #(
  parameter int unsigned PACK_W = 40
) (
  input  logic              CLK,
  input  logic              MR,
  input  logic              Send_in_a,
  output logic              Ack_out_a,
  input  logic [PACK_W-1:0] PACKET_IN_A,
  input  logic              Send_in_b,
  output logic              Ack_out_b,
  input  logic [PACK_W-1:0] PACKET_IN_B,
  output logic              Send_out,
  input  logic              Ack_in,
  output logic [PACK_W-1:0] PACKET_OUT
);

  typedef enum logic {ChA = 1'b0, ChB = 1'b1} chan_e;

  logic              full_q, full_d;
  chan_e             last_q, last_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              send_q, send_d;
  logic [PACK_W-1:0] buf_q, buf_d;
  logic [PACK_W-1:0] pkt_q, pkt_d;

  logic elig_a, elig_b;
  logic grant_a, grant_b;

  // Eligibility and round-robin grant; full_q is the registered flag, so a
  // buffer released at this edge cannot be refilled until the next one.
  always_comb begin
    elig_a  = Send_in_a & ~ack_a_q & ~full_q;
    elig_b  = Send_in_b & ~ack_b_q & ~full_q;
    grant_a = elig_a & (~elig_b | (last_q == ChB));
    grant_b = elig_b & (~elig_a | (last_q == ChA));
  end

  // Next-state for input acks, buffer, output request and packet register.
  always_comb begin
    full_d  = full_q;
    last_d  = last_q;
    ack_a_d = ack_a_q;
    ack_b_d = ack_b_q;
    send_d  = send_q;
    buf_d   = buf_q;
    pkt_d   = pkt_q;

    // Input side: capture on grant, return-to-zero when the producer drops Send.
    if (grant_a) begin
      buf_d   = PACKET_IN_A;
      full_d  = 1'b1;
      ack_a_d = 1'b1;
      last_d  = ChA;
    end else if (ack_a_q && !Send_in_a) begin
      ack_a_d = 1'b0;
    end

    if (grant_b) begin
      buf_d   = PACKET_IN_B;
      full_d  = 1'b1;
      ack_b_d = 1'b1;
      last_d  = ChB;
    end else if (ack_b_q && !Send_in_b) begin
      ack_b_d = 1'b0;
    end

    // Output side: a new request waits for the downstream ack to return to zero.
    if (full_q && !send_q && !Ack_in) begin
      send_d = 1'b1;
      pkt_d  = buf_q;
    end else if (send_q && Ack_in) begin
      send_d = 1'b0;
      full_d = 1'b0;
    end
  end

  // State registers with synchronous master reset; an in-flight packet is dropped.
  always_ff @(posedge CLK) begin
    if (MR) begin
      full_q  <= 1'b0;
      last_q  <= ChB;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      send_q  <= 1'b0;
      buf_q   <= '0;
      pkt_q   <= '0;
    end else begin
      full_q  <= full_d;
      last_q  <= last_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      send_q  <= send_d;
      buf_q   <= buf_d;
      pkt_q   <= pkt_d;
    end
  end

  assign Ack_out_a  = ack_a_q;
  assign Ack_out_b  = ack_b_q;
  assign Send_out   = send_q;
  assign PACKET_OUT = pkt_q;

endmodule

// File: tb/tb_merge_stage.sv
// tb_merge_stage: directed scenarios plus a randomized run of reactive
// producers/consumer checked against a grant-order scoreboard.
module tb_merge_stage;

  localparam int unsigned PW = 40;
  localparam int NRAND = 25;

  logic          CLK = 1'b0;
  logic          MR;
  logic          Send_in_a, Send_in_b, Ack_in;
  logic          Ack_out_a, Ack_out_b, Send_out;
  logic [PW-1:0] PACKET_IN_A, PACKET_IN_B, PACKET_OUT;

  int total = 0;
  int bad   = 0;

  merge_stage #(.PACK_W(PW)) dut (
    .CLK        (CLK),
    .MR         (MR),
    .Send_in_a  (Send_in_a),
    .Ack_out_a  (Ack_out_a),
    .PACKET_IN_A(PACKET_IN_A),
    .Send_in_b  (Send_in_b),
    .Ack_out_b  (Ack_out_b),
    .PACKET_IN_B(PACKET_IN_B),
    .Send_out   (Send_out),
    .Ack_in     (Ack_in),
    .PACKET_OUT (PACKET_OUT)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic do_reset;
    MR = 1'b1; Send_in_a = 1'b0; Send_in_b = 1'b0; Ack_in = 1'b0;
    PACKET_IN_A = '0; PACKET_IN_B = '0;
    tick; tick;
    MR = 1'b0;
  endtask

  task automatic test_reset;
    MR = 1'b1; Send_in_a = 1'b1; Send_in_b = 1'b0; Ack_in = 1'b0;
    PACKET_IN_A = 40'h00000000AA; PACKET_IN_B = '0;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if ({Ack_out_a, Ack_out_b, Send_out, PACKET_OUT} !== '0) begin
        bad++;
        $display("FAIL reset_outs cyc=%0d got=%b/%b/%b/%h exp=0", i, Ack_out_a, Ack_out_b,
                 Send_out, PACKET_OUT);
      end
    end
    MR = 1'b0;
    tick;
    total++;
    if (Ack_out_a !== 1'b1 || Send_out !== 1'b0) begin
      bad++; $display("FAIL reset_ack_a got ack=%b send=%b exp ack=1 send=0", Ack_out_a, Send_out);
    end
    tick;
    total++;
    if (Send_out !== 1'b1 || PACKET_OUT !== 40'hAA) begin
      bad++; $display("FAIL reset_first_out got send=%b pkt=%h exp send=1 pkt=aa", Send_out,
                      PACKET_OUT);
    end
    Send_in_a = 1'b0; Ack_in = 1'b1;
    tick;
    total++;
    if (Send_out !== 1'b0 || Ack_out_a !== 1'b0) begin
      bad++; $display("FAIL reset_rtz got send=%b ack=%b exp 0/0", Send_out, Ack_out_a);
    end
    Ack_in = 1'b0;
  endtask

  task automatic test_single_b;
    do_reset;
    Send_in_b = 1'b1; PACKET_IN_B = 40'h123456789A;
    tick;
    total++;
    if (Ack_out_b !== 1'b1 || Ack_out_a !== 1'b0 || Send_out !== 1'b0) begin
      bad++; $display("FAIL single_b_ack got ackb=%b acka=%b send=%b exp 1/0/0", Ack_out_b,
                      Ack_out_a, Send_out);
    end
    tick;
    total++;
    if (Send_out !== 1'b1 || PACKET_OUT !== 40'h123456789A) begin
      bad++; $display("FAIL single_b_out got send=%b pkt=%h exp 1/123456789a", Send_out,
                      PACKET_OUT);
    end
    Ack_in = 1'b1; Send_in_b = 1'b0;
    tick;
    total++;
    if (Send_out !== 1'b0 || Ack_out_b !== 1'b0) begin
      bad++; $display("FAIL single_b_rtz got send=%b ackb=%b exp 0/0", Send_out, Ack_out_b);
    end
    Ack_in = 1'b0;
  endtask

  // Producers re-request as soon as their ack returns to zero; consumer acks at once.
  task automatic test_tie;
    logic [PW-1:0] seen[$];
    logic [PW-1:0] want[4];
    logic prev_send;
    int cyc;
    want[0] = 40'h0A; want[1] = 40'h0B; want[2] = 40'h0A; want[3] = 40'h0B;
    do_reset;
    PACKET_IN_A = 40'h0A; PACKET_IN_B = 40'h0B;
    Send_in_a = 1'b1; Send_in_b = 1'b1;
    prev_send = 1'b0; cyc = 0;
    while (seen.size() < 4 && cyc < 80) begin
      tick; cyc++;
      if (Send_out && !prev_send) seen.push_back(PACKET_OUT);
      prev_send = Send_out;
      if (Send_in_a && Ack_out_a) Send_in_a = 1'b0;
      else if (!Send_in_a && !Ack_out_a) Send_in_a = 1'b1;
      if (Send_in_b && Ack_out_b) Send_in_b = 1'b0;
      else if (!Send_in_b && !Ack_out_b) Send_in_b = 1'b1;
      Ack_in = Send_out;
    end
    total++;
    if (seen.size() != 4) begin
      bad++; $display("FAIL tie_count got=%0d exp=4", seen.size());
    end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      total++;
      if (seen[i] !== want[i]) begin
        bad++; $display("FAIL tie_order idx=%0d got=%h exp=%h", i, seen[i], want[i]);
      end
    end
    Send_in_a = 1'b0; Send_in_b = 1'b0; Ack_in = 1'b0;
  endtask

  task automatic test_backpressure;
    do_reset;
    Send_in_a = 1'b1; PACKET_IN_A = 40'h11;
    tick;
    Send_in_a = 1'b0; Send_in_b = 1'b1; PACKET_IN_B = 40'h22;
    tick;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (Send_out !== 1'b1 || PACKET_OUT !== 40'h11 || Ack_out_b !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got send=%b pkt=%h ackb=%b exp 1/11/0", i,
                        Send_out, PACKET_OUT, Ack_out_b);
      end
      tick;
    end
    Ack_in = 1'b1;
    tick;
    total++;
    if (Send_out !== 1'b0 || Ack_out_b !== 1'b0) begin
      bad++; $display("FAIL bp_release got send=%b ackb=%b exp 0/0", Send_out, Ack_out_b);
    end
    Ack_in = 1'b0;
    tick;
    total++;
    if (Ack_out_b !== 1'b1) begin
      bad++; $display("FAIL bp_capture_b got ackb=%b exp 1", Ack_out_b);
    end
    Send_in_b = 1'b0;
    tick;
    total++;
    if (Send_out !== 1'b1 || PACKET_OUT !== 40'h22) begin
      bad++; $display("FAIL bp_out_b got send=%b pkt=%h exp 1/22", Send_out, PACKET_OUT);
    end
  endtask

  task automatic test_out_rtz;
    do_reset;
    Send_in_a = 1'b1; PACKET_IN_A = 40'h33;
    tick;
    Send_in_a = 1'b0; Send_in_b = 1'b1; PACKET_IN_B = 40'h44;
    tick;
    Ack_in = 1'b1;
    tick;
    tick;
    total++;
    if (Ack_out_b !== 1'b1) begin
      bad++; $display("FAIL rtz_capture got ackb=%b exp 1", Ack_out_b);
    end
    Send_in_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (Send_out !== 1'b0) begin
        bad++; $display("FAIL rtz_hold cyc=%0d got send=%b exp 0", i, Send_out);
      end
      tick;
    end
    total++;
    if (Send_out !== 1'b0) begin
      bad++; $display("FAIL rtz_hold_last got send=%b exp 0", Send_out);
    end
    Ack_in = 1'b0;
    tick;
    total++;
    if (Send_out !== 1'b1 || PACKET_OUT !== 40'h44) begin
      bad++; $display("FAIL rtz_rise got send=%b pkt=%h exp 1/44", Send_out, PACKET_OUT);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    Send_in_a = 1'b1; PACKET_IN_A = 40'h55;
    tick; tick;
    total++;
    if (Send_out !== 1'b1 || Ack_out_a !== 1'b1) begin
      bad++; $display("FAIL mid_setup got send=%b acka=%b exp 1/1", Send_out, Ack_out_a);
    end
    MR = 1'b1;
    tick;
    total++;
    if ({Ack_out_a, Ack_out_b, Send_out, PACKET_OUT} !== '0) begin
      bad++; $display("FAIL mid_reset got %b/%b/%b/%h exp 0", Ack_out_a, Ack_out_b, Send_out,
                      PACKET_OUT);
    end
    MR = 1'b0; Send_in_a = 1'b0;
    tick;
    total++;
    if (Send_out !== 1'b0 || Ack_out_a !== 1'b0) begin
      bad++; $display("FAIL mid_dropped got send=%b acka=%b exp 0/0", Send_out, Ack_out_a);
    end
    Send_in_a = 1'b1; PACKET_IN_A = 40'h66;
    tick;
    total++;
    if (Ack_out_a !== 1'b1) begin
      bad++; $display("FAIL mid_fresh_ack got acka=%b exp 1", Ack_out_a);
    end
    tick;
    total++;
    if (Send_out !== 1'b1 || PACKET_OUT !== 40'h66) begin
      bad++; $display("FAIL mid_fresh_out got send=%b pkt=%h exp 1/66", Send_out, PACKET_OUT);
    end
    Ack_in = 1'b1; Send_in_a = 1'b0;
    tick;
    Ack_in = 1'b0;
  endtask

  // Random producers/consumer; every granted packet must leave once, in grant order.
  task automatic test_random;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] held, want;
    logic got_a, got_b, prev_send;
    int na, nb, da, db, dc, outs, cyc;
    do_reset;
    na = 0; nb = 0; outs = 0; cyc = 0;
    da = $urandom_range(0, 3); db = $urandom_range(0, 3); dc = 0;
    got_a = 1'b0; got_b = 1'b0; prev_send = 1'b0; held = '0;
    while (outs < 2 * NRAND && cyc < 5000) begin
      tick; cyc++;
      if (Send_out && !prev_send) begin
        outs++;
        total++;
        if (Ack_in !== 1'b0) begin
          bad++; $display("FAIL rnd_send_while_ack cyc=%0d got ack_in=%b exp 0", cyc, Ack_in);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_unexpected cyc=%0d got pkt=%h exp none", cyc, PACKET_OUT);
        end else begin
          want = exp_q.pop_front();
          if (PACKET_OUT !== want) begin
            bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, PACKET_OUT, want);
          end
        end
        held = PACKET_OUT;
      end else if (Send_out && prev_send && PACKET_OUT !== held) begin
        total++; bad++;
        $display("FAIL rnd_hold cyc=%0d got=%h exp=%h", cyc, PACKET_OUT, held);
      end
      prev_send = Send_out;

      if (Send_in_a && Ack_out_a && !got_a) begin
        exp_q.push_back(PACKET_IN_A); got_a = 1'b1; da = $urandom_range(0, 3);
      end
      if (Send_in_b && Ack_out_b && !got_b) begin
        exp_q.push_back(PACKET_IN_B); got_b = 1'b1; db = $urandom_range(0, 3);
      end

      if (Send_in_a && got_a) begin
        if (da == 0) begin Send_in_a = 1'b0; da = $urandom_range(0, 3); end
        else da--;
      end else if (!Send_in_a && !Ack_out_a && na < NRAND) begin
        if (da == 0) begin
          Send_in_a = 1'b1; PACKET_IN_A = {8'($urandom), $urandom}; got_a = 1'b0; na++;
        end else da--;
      end
      if (Send_in_b && got_b) begin
        if (db == 0) begin Send_in_b = 1'b0; db = $urandom_range(0, 3); end
        else db--;
      end else if (!Send_in_b && !Ack_out_b && nb < NRAND) begin
        if (db == 0) begin
          Send_in_b = 1'b1; PACKET_IN_B = {8'($urandom), $urandom}; got_b = 1'b0; nb++;
        end else db--;
      end

      if (Send_out && !Ack_in) begin
        if (dc == 0) begin Ack_in = 1'b1; dc = $urandom_range(0, 3); end
        else dc--;
      end else if (!Send_out && Ack_in) begin
        if (dc == 0) begin Ack_in = 1'b0; dc = $urandom_range(0, 4); end
        else dc--;
      end
    end
    total++;
    if (outs != 2 * NRAND || exp_q.size() != 0) begin
      bad++; $display("FAIL rnd_complete got outs=%0d left=%0d exp outs=%0d left=0", outs,
                      exp_q.size(), 2 * NRAND);
    end
    Send_in_a = 1'b0; Send_in_b = 1'b0; Ack_in = 1'b0;
  endtask

  initial begin
    MR = 1'b1; Send_in_a = 1'b0; Send_in_b = 1'b0; Ack_in = 1'b0;
    PACKET_IN_A = '0; PACKET_IN_B = '0;
    test_reset;
    test_single_b;
    test_tie;
    test_backpressure;
    test_out_rtz;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
